// File: rtl/decode_exec_pkg.sv
// Shared decode constants, ALU operation encoding and the ID/EX control bundle
// for the decode/execute slice.
package decode_exec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_SLT = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    // Only the control that travels past ID; branch/jump resolve in ID.
    typedef struct packed {
        logic    reg_wr;
        logic    mem_wr;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_exec_alu_core.sv
// EX-stage ALU: ADD/SUB/signed SLT/XOR with zero flag, wrapping arithmetic.
// Signed-overflow flag for ADD/SUB exists only when DECODE_EXEC_OVF_EN is defined.
module alu_core
    import decode_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result,
    output logic                zero
`ifdef DECODE_EXEC_OVF_EN
    , output logic              ovf
`endif
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = sum;
        case (op)
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: begin
                result    = '0;
                result[0] = ($signed(a) < $signed(b));
            end
            ALU_XOR: result = a ^ b;
            default: result = sum;
        endcase
    end

    assign zero = (result == '0);

`ifdef DECODE_EXEC_OVF_EN
    // Overflow when the result sign disagrees with what the operand signs allow.
    always_comb begin
        ovf = 1'b0;
        case (op)
            ALU_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
            ALU_SUB: ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/decode_exec_unit.sv
// ID/EX slice: decode, bne/j/jr resolution in ID, ID/EX register, EX ALU.
// Defining DECODE_EXEC_OVF_EN adds the alu_ovf_ex output.
module decode_exec_unit
    import decode_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_id,
    input  logic [DATA_W-1:0]   rs_data_id,
    input  logic [DATA_W-1:0]   rt_data_id,
    input  logic                bubble_id,
    output logic                branch_id,
    output logic                jump_id,
    output logic                jump_r_id,
    output logic                rs_eq_rt_id,
    output logic                branch_taken_id,
    output logic [4:0]          aw_id,
    output logic [DATA_W-1:0]   alu_result_ex,
    output logic                alu_zero_ex,
    output logic [DATA_W-1:0]   rt_data_ex,
    output logic [4:0]          aw_ex,
    output logic                reg_wr_ex,
    output logic                mem_wr_ex,
    output logic                mem_to_reg_ex,
    output logic                reg_dst_ex,
    output logic [31:0]         instr_ex
`ifdef DECODE_EXEC_OVF_EN
    , output logic              alu_ovf_ex
`endif
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    ctrl_t             ctrl_id;

    ctrl_t             ctrl_d,   ctrl_q;
    logic [DATA_W-1:0] rs_d,     rs_q;
    logic [DATA_W-1:0] rt_d,     rt_q;
    logic [4:0]        aw_d,     aw_q;
    logic [31:0]       instr_d,  instr_q;

    logic [DATA_W-1:0] imm_ext_ex;
    logic [DATA_W-1:0] alu_b_ex;

    assign opcode = instr_id[31:26];
    assign funct  = instr_id[5:0];

    always_comb begin
        ctrl_id   = CTRL_NOP;
        branch_id = 1'b0;
        jump_id   = 1'b0;
        jump_r_id = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT, FN_XOR: begin
                        ctrl_id.reg_dst = 1'b1;
                        ctrl_id.reg_wr  = 1'b1;
                        case (funct)
                            FN_SUB:  ctrl_id.alu_op = ALU_SUB;
                            FN_SLT:  ctrl_id.alu_op = ALU_SLT;
                            FN_XOR:  ctrl_id.alu_op = ALU_XOR;
                            default: ctrl_id.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_JR:   jump_r_id = 1'b1;
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrl_id.reg_wr     = 1'b1;
                ctrl_id.alu_src    = 1'b1;
                ctrl_id.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_id.mem_wr  = 1'b1;
                ctrl_id.alu_src = 1'b1;
            end
            OP_BNE: begin
                branch_id      = 1'b1;
                ctrl_id.alu_op = ALU_SUB;
            end
            OP_J:    jump_id = 1'b1;
            default: ;
        endcase
    end

    assign aw_id           = ctrl_id.reg_dst ? instr_id[15:11] : instr_id[20:16];
    assign rs_eq_rt_id     = (rs_data_id == rt_data_id);
    assign branch_taken_id = branch_id & ~rs_eq_rt_id;

    // A bubble kills control and the instruction; operand data passes through harmlessly.
    always_comb begin
        ctrl_d  = bubble_id ? CTRL_NOP : ctrl_id;
        instr_d = bubble_id ? 32'h0    : instr_id;
        rs_d    = rs_data_id;
        rt_d    = rt_data_id;
        aw_d    = aw_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= CTRL_NOP;
            rs_q    <= '0;
            rt_q    <= '0;
            aw_q    <= '0;
            instr_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            aw_q    <= aw_d;
            instr_q <= instr_d;
        end
    end

    assign imm_ext_ex = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign alu_b_ex   = ctrl_q.alu_src ? imm_ext_ex : rt_q;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .op     (ctrl_q.alu_op),
        .a      (rs_q),
        .b      (alu_b_ex),
        .result (alu_result_ex),
        .zero   (alu_zero_ex)
`ifdef DECODE_EXEC_OVF_EN
        , .ovf  (alu_ovf_ex)
`endif
    );

    assign rt_data_ex    = rt_q;
    assign aw_ex         = aw_q;
    assign reg_wr_ex     = ctrl_q.reg_wr;
    assign mem_wr_ex     = ctrl_q.mem_wr;
    assign mem_to_reg_ex = ctrl_q.mem_to_reg;
    assign reg_dst_ex    = ctrl_q.reg_dst;
    assign instr_ex      = instr_q;

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed plus randomized bench for decode_exec_unit against an instruction-level
// reference model; covers alu_ovf_ex when DECODE_EXEC_OVF_EN is defined.
module tb_decode_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic [31:0] rs_data_id;
    logic [31:0] rt_data_id;
    logic        bubble_id;
    logic        branch_id, jump_id, jump_r_id, rs_eq_rt_id, branch_taken_id;
    logic [4:0]  aw_id;
    logic [31:0] alu_result_ex;
    logic        alu_zero_ex;
    logic [31:0] rt_data_ex;
    logic [4:0]  aw_ex;
    logic        reg_wr_ex, mem_wr_ex, mem_to_reg_ex, reg_dst_ex;
    logic [31:0] instr_ex;
`ifdef DECODE_EXEC_OVF_EN
    logic        alu_ovf_ex;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_exec_unit #(.DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_id        (instr_id),
        .rs_data_id      (rs_data_id),
        .rt_data_id      (rt_data_id),
        .bubble_id       (bubble_id),
        .branch_id       (branch_id),
        .jump_id         (jump_id),
        .jump_r_id       (jump_r_id),
        .rs_eq_rt_id     (rs_eq_rt_id),
        .branch_taken_id (branch_taken_id),
        .aw_id           (aw_id),
        .alu_result_ex   (alu_result_ex),
        .alu_zero_ex     (alu_zero_ex),
        .rt_data_ex      (rt_data_ex),
        .aw_ex           (aw_ex),
        .reg_wr_ex       (reg_wr_ex),
        .mem_wr_ex       (mem_wr_ex),
        .mem_to_reg_ex   (mem_to_reg_ex),
        .reg_dst_ex      (reg_dst_ex),
        .instr_ex        (instr_ex)
`ifdef DECODE_EXEC_OVF_EN
        , .alu_ovf_ex    (alu_ovf_ex)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        enc_r = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        enc_i = {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Reference model: classify the instruction by mnemonic, then apply its meaning.
    task automatic step(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input logic bub);
        logic [5:0]  op;
        logic [5:0]  fn;
        bit          is_add, is_sub, is_slt, is_xor, is_jr, is_lw, is_sw, is_bne, is_j, is_ralu;
        logic [4:0]  e_aw;
        logic [31:0] e_res;
        longint      sa, sb, wide;
        bit          e_ovf;
        op = ins[31:26];
        fn = ins[5:0];
        is_add  = (op == 6'h00) && (fn == 6'h20);
        is_sub  = (op == 6'h00) && (fn == 6'h22);
        is_slt  = (op == 6'h00) && (fn == 6'h2A);
        is_xor  = (op == 6'h00) && (fn == 6'h26);
        is_jr   = (op == 6'h00) && (fn == 6'h08);
        is_lw   = (op == 6'h23);
        is_sw   = (op == 6'h2B);
        is_bne  = (op == 6'h05);
        is_j    = (op == 6'h02);
        is_ralu = is_add || is_sub || is_slt || is_xor;
        e_aw    = is_ralu ? ins[15:11] : ins[20:16];

        @(negedge clk);
        instr_id   = ins;
        rs_data_id = rs;
        rt_data_id = rt;
        bubble_id  = bub;
        #1;
        chk("branch_id",       branch_id,       32'(is_bne));
        chk("jump_id",         jump_id,         32'(is_j));
        chk("jump_r_id",       jump_r_id,       32'(is_jr));
        chk("rs_eq_rt_id",     rs_eq_rt_id,     32'(rs == rt));
        chk("branch_taken_id", branch_taken_id, 32'(is_bne && (rs != rt)));
        chk("aw_id",           aw_id,           32'(e_aw));

        sa = longint'($signed(rs));
        if (is_lw || is_sw) sb = longint'($signed(ins[15:0]));
        else                sb = longint'($signed(rt));
        e_ovf = 1'b0;
        if (is_slt) begin
            e_res = (sa < sb) ? 32'd1 : 32'd0;
        end else if (is_xor) begin
            e_res = rs ^ rt;
        end else if (is_sub || is_bne) begin
            wide  = sa - sb;
            e_res = 32'(wide);
            e_ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else begin
            wide  = sa + sb;
            e_res = 32'(wide);
            e_ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end

        @(posedge clk);
        #1;
        chk("reg_wr_ex",     reg_wr_ex,     32'(!bub && (is_ralu || is_lw)));
        chk("mem_wr_ex",     mem_wr_ex,     32'(!bub && is_sw));
        chk("mem_to_reg_ex", mem_to_reg_ex, 32'(!bub && is_lw));
        chk("reg_dst_ex",    reg_dst_ex,    32'(!bub && is_ralu));
        chk("instr_ex",      instr_ex,      bub ? 32'h0 : ins);
        if (!bub) begin
            chk("aw_ex",         aw_ex,         32'(e_aw));
            chk("rt_data_ex",    rt_data_ex,    rt);
            chk("alu_result_ex", alu_result_ex, e_res);
            chk("alu_zero_ex",   alu_zero_ex,   32'(e_res == 32'h0));
`ifdef DECODE_EXEC_OVF_EN
            chk("alu_ovf_ex",    alu_ovf_ex,    32'(e_ovf));
`endif
        end
    endtask

    initial begin
        logic [31:0] ins, rs, rt;
        logic [5:0]  op, fn;
        int          kind;

        reset      = 1'b1;
        instr_id   = 32'h0;
        rs_data_id = 32'h0;
        rt_data_id = 32'h0;
        bubble_id  = 1'b0;
        #12;
        chk("rst reg_wr_ex",     reg_wr_ex,     32'h0);
        chk("rst mem_wr_ex",     mem_wr_ex,     32'h0);
        chk("rst instr_ex",      instr_ex,      32'h0);
        chk("rst alu_result_ex", alu_result_ex, 32'h0);
        chk("rst alu_zero_ex",   alu_zero_ex,   32'h1);
        reset = 1'b0;

        step(32'h00221820, 32'd5, 32'd7, 1'b0);
        chk("add result 12", alu_result_ex, 32'd12);
        step(32'h8C24FFFC, 32'h100, 32'h0, 1'b0);
        chk("lw result FC", alu_result_ex, 32'hFC);
        step(enc_i(6'h05, 1, 2, 16'h0010), 32'd9, 32'd9, 1'b0);
        step(enc_i(6'h05, 1, 2, 16'h0010), 32'd9, 32'd8, 1'b0);
        step(enc_r(1, 2, 5, 6'h2A), 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("slt result 1", alu_result_ex, 32'd1);
        step(enc_r(1, 2, 6, 6'h26), 32'h0000F0F0, 32'h0000FFFF, 1'b0);
        chk("xor result", alu_result_ex, 32'h00000F0F);
        step(enc_r(1, 2, 7, 6'h22), 32'd5, 32'd5, 1'b0);
        chk("sub zero flag", alu_zero_ex, 32'h1);
        step(enc_i(6'h2B, 3, 4, 16'h0008), 32'h40, 32'h1234, 1'b1);
        step(enc_r(1, 2, 3, 6'h20), 32'h7FFFFFFF, 32'd1, 1'b0);
        step(enc_i(6'h02, 0, 0, 16'h0100), 32'd1, 32'd2, 1'b0);
        step(enc_r(9, 0, 0, 6'h08), 32'h80, 32'd0, 1'b0);
        step(enc_i(6'h3F, 1, 2, 16'h0001), 32'd3, 32'd4, 1'b0);

        // Asynchronous reset landing between edges with a writing instruction in EX.
        step(enc_r(1, 2, 3, 6'h20), 32'd5, 32'd7, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst reg_wr_ex",     reg_wr_ex,     32'h0);
        chk("midrst mem_wr_ex",     mem_wr_ex,     32'h0);
        chk("midrst instr_ex",      instr_ex,      32'h0);
        chk("midrst alu_result_ex", alu_result_ex, 32'h0);
        chk("midrst alu_zero_ex",   alu_zero_ex,   32'h1);
        chk("midrst aw_id",         aw_id,         32'd3);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 10));
            rs   = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = rs;
                1:       rt = 32'h80000000 | 32'($urandom_range(0, 3));
                default: rt = $urandom;
            endcase
            case (kind)
                0: ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'h20);
                1: ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'h22);
                2: ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'h2A);
                3: ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'h26);
                4: ins = enc_r(int'($urandom_range(0, 31)), 0, 0, 6'h08);
                5: ins = enc_i(6'h23, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
                6: ins = enc_i(6'h2B, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
                7: ins = enc_i(6'h05, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
                8: ins = {6'h02, 26'($urandom)};
                9: begin
                    op = 6'($urandom);
                    while (op == 6'h00 || op == 6'h02 || op == 6'h05 || op == 6'h23 || op == 6'h2B)
                        op = 6'($urandom);
                    ins = {op, 26'($urandom)};
                end
                default: begin
                    fn = 6'($urandom);
                    while (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A || fn == 6'h26 || fn == 6'h08)
                        fn = 6'($urandom);
                    ins = {6'h00, 20'($urandom), fn};
                end
            endcase
            step(ins, rs, rt, ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
